// File: rtl/block_transpose_ctrl_if.sv
// Handshake, coefficient stream and SRAM port bundle for the IDCT block transpose buffer.
interface block_transpose_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             transpose;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [5:0]       sram_a;
  logic [WIDTH-1:0] sram_di;
  logic             sram_en;
  logic             sram_we;
  logic [WIDTH-1:0] sram_do;

  modport slave (
    input  in_data, in_valid, transpose, out_ready, sram_do,
    output in_ready, out_data, out_valid, out_last, sram_a, sram_di, sram_en, sram_we
  );

  modport master (
    output in_data, in_valid, transpose, out_ready, sram_do,
    input  in_ready, out_data, out_valid, out_last, sram_a, sram_di, sram_en, sram_we
  );
endinterface

// File: rtl/block_transpose_ctrl.sv
// Fills a 64-word single-port SRAM with one 8x8 block, then drains it row- or column-major.
// Read latency 1 cycle; the SRAM DO register is the output holding register, so reads wait for a free slot.
module block_transpose_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                  CLK,
  input logic                  RST,
  block_transpose_ctrl_if.slave bus
);
  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state, state_nx;
  logic [5:0]       wcnt;
  logic [6:0]       rcnt;
  logic             tr_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             accept;
  logic             issue;
  logic [WIDTH-1:0] di_w;
  logic [WIDTH-1:0] do_w;

  assign di_w          = bus.in_data;
  assign bus.sram_di   = di_w;
  assign do_w          = bus.sram_do;
  assign bus.out_data  = do_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

  // Reset gates the SRAM strobe combinationally so the array is never touched while RST is high.
  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    issue        = 1'b0;
    bus.in_ready = 1'b0;
    bus.sram_en  = 1'b0;
    bus.sram_we  = 1'b0;
    bus.sram_a   = wcnt;
    if (!RST) begin
      case (state)
        FILL: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            accept      = 1'b1;
            bus.sram_en = 1'b1;
            bus.sram_we = 1'b1;
            if (wcnt == 6'd63) state_nx = DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid_q || bus.out_ready) begin
            issue       = 1'b1;
            bus.sram_en = 1'b1;
            bus.sram_a  = tr_q ? {rcnt[2:0], rcnt[5:3]} : rcnt[5:0];
            if (rcnt == 7'd63) state_nx = FILL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= FILL;
      wcnt        <= '0;
      rcnt        <= '0;
      tr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wcnt <= wcnt + 6'd1;
        if (wcnt == 6'd0)  tr_q <= bus.transpose;
        if (wcnt == 6'd63) rcnt <= '0;
      end
      if (issue) begin
        rcnt        <= rcnt + 7'd1;
        out_valid_q <= 1'b1;
        out_last_q  <= (rcnt == 7'd63);
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_block_transpose_ctrl.sv
// Directed bench for block_transpose_ctrl with a registered-output 64x16 SRAM model.
module tb_block_transpose_ctrl;
  localparam int W = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  block_transpose_ctrl_if #(.WIDTH(W)) bus ();
  block_transpose_ctrl #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  logic [W-1:0] mem [64];
  logic [W-1:0] do_r = '0;
  always @(posedge CLK) begin
    if (bus.sram_en) begin
      if (bus.sram_we) mem[bus.sram_a] <= bus.sram_di;
      else             do_r <= mem[bus.sram_a];
    end
  end
  assign bus.sram_do = do_r;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] got_d [80];
  logic         got_l [80];
  int got_n, first_cyc, last_cyc;

  function automatic int col_idx(input int k);
    return (k % 8) * 8 + k / 8;
  endfunction

  // Feeds 64 consecutive values; transpose differs from index 0 on all later indices.
  task automatic fill(input int base, input bit tr0, output int cyc);
    int n;
    n = 0;
    cyc = 0;
    while (n < 64 && cyc < 300) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = W'(base + n);
      bus.transpose = (n == 0) ? tr0 : ~tr0;
      @(negedge CLK);
      if (bus.in_ready) n++;
      @(posedge CLK); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int target);
    int cyc;
    cyc = 0;
    got_n = 0;
    first_cyc = -1;
    last_cyc = -1;
    bus.out_ready = 1'b1;
    while (got_n < target && cyc < 400) begin
      @(negedge CLK);
      if (bus.out_valid) begin
        got_d[got_n] = bus.out_data;
        got_l[got_n] = bus.out_last;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got_n++;
      end
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #2;
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last got %b exp 0", bus.out_last); end
    checks++; if (bus.sram_en !== 1'b0)   begin errors++; $display("FAIL rst_sram_en got %b exp 0", bus.sram_en); end
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rel_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got %b exp 0", bus.out_valid); end
    @(posedge CLK); #1;
  endtask

  task automatic test_row_major();
    int cyc;
    fill(0, 1'b0, cyc);
    checks++; if (cyc != 64) begin errors++; $display("FAIL row_fill_cycles got %0d exp 64", cyc); end
    drain(64);
    checks++; if (got_n != 64) begin errors++; $display("FAIL row_count got %0d exp 64", got_n); end
    checks++; if (first_cyc != 1) begin errors++; $display("FAIL row_first_latency got %0d exp 1", first_cyc); end
    checks++; if (last_cyc - first_cyc != 63) begin errors++; $display("FAIL row_span got %0d exp 63", last_cyc - first_cyc); end
    for (int k = 0; k < 64; k++) begin
      checks++; if (got_d[k] !== W'(k)) begin errors++; $display("FAIL row_data[%0d] got %0d exp %0d", k, got_d[k], k); end
      checks++; if (got_l[k] !== (k == 63)) begin errors++; $display("FAIL row_last[%0d] got %b exp %b", k, got_l[k], k == 63); end
    end
  endtask

  task automatic test_col_major();
    int cyc;
    fill(0, 1'b1, cyc);
    checks++; if (cyc != 64) begin errors++; $display("FAIL col_fill_cycles got %0d exp 64", cyc); end
    drain(64);
    checks++; if (got_n != 64) begin errors++; $display("FAIL col_count got %0d exp 64", got_n); end
    for (int k = 0; k < 64; k++) begin
      checks++; if (got_d[k] !== W'(col_idx(k))) begin errors++; $display("FAIL col_data[%0d] got %0d exp %0d", k, got_d[k], col_idx(k)); end
      checks++; if (got_l[k] !== (k == 63)) begin errors++; $display("FAIL col_last[%0d] got %b exp %b", k, got_l[k], k == 63); end
    end
  endtask

  task automatic test_stall();
    int cyc, n;
    bit was_stall;
    logic [W-1:0] held;
    fill(0, 1'b0, cyc);
    n = 0;
    cyc = 0;
    was_stall = 1'b0;
    held = '0;
    while (n < 64 && cyc < 400) begin
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge CLK);
      if (bus.out_valid) begin
        if (was_stall) begin
          checks++; if (bus.out_data !== held) begin errors++; $display("FAIL stall_hold got %0d exp %0d", bus.out_data, held); end
        end
        if (bus.out_ready) begin
          checks++; if (bus.out_data !== W'(n)) begin errors++; $display("FAIL stall_data[%0d] got %0d exp %0d", n, bus.out_data, n); end
          checks++; if (bus.out_last !== (n == 63)) begin errors++; $display("FAIL stall_last[%0d] got %b exp %b", n, bus.out_last, n == 63); end
          n++;
          was_stall = 1'b0;
        end else begin
          checks++; if (bus.sram_en !== 1'b0) begin errors++; $display("FAIL stall_sram_en got %b exp 0", bus.sram_en); end
          held = bus.out_data;
          was_stall = 1'b1;
        end
      end
      @(posedge CLK); #1;
      cyc++;
    end
    bus.out_ready = 1'b1;
    checks++; if (n != 64) begin errors++; $display("FAIL stall_count got %0d exp 64", n); end
  endtask

  task automatic test_back_to_back();
    int cyc, n;
    fill(0, 1'b0, cyc);
    n = 0;
    cyc = 0;
    while (cyc < 200) begin
      bus.out_ready = (n < 63);
      @(negedge CLK);
      if (bus.out_valid && n == 63) break;
      if (bus.out_valid && bus.out_ready) n++;
      @(posedge CLK); #1;
      cyc++;
    end
    checks++; if (bus.out_data !== W'(63)) begin errors++; $display("FAIL b2b_a_last_data got %0d exp 63", bus.out_data); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL b2b_a_last_flag got %b exp 1", bus.out_last); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", bus.in_ready); end
    @(posedge CLK); #1;
    fill(100, 1'b0, cyc);
    checks++; if (cyc != 64) begin errors++; $display("FAIL b2b_fill_cycles got %0d exp 64", cyc); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_data !== W'(63)) begin errors++; $display("FAIL b2b_hold_data got %0d exp 63", bus.out_data); end
      checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL b2b_hold_last got %b exp 1", bus.out_last); end
      checks++; if (bus.sram_en !== 1'b0) begin errors++; $display("FAIL b2b_no_issue got %b exp 0", bus.sram_en); end
      @(posedge CLK); #1;
    end
    drain(65);
    checks++; if (got_n != 65) begin errors++; $display("FAIL b2b_count got %0d exp 65", got_n); end
    checks++; if (got_d[0] !== W'(63) || got_l[0] !== 1'b1) begin errors++; $display("FAIL b2b_first got %0d/%b exp 63/1", got_d[0], got_l[0]); end
    for (int k = 1; k < 65; k++) begin
      checks++; if (got_d[k] !== W'(99 + k)) begin errors++; $display("FAIL b2b_data[%0d] got %0d exp %0d", k, got_d[k], 99 + k); end
      checks++; if (got_l[k] !== (k == 64)) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", k, got_l[k], k == 64); end
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc, n;
    fill(0, 1'b0, cyc);
    bus.out_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 20 && cyc < 200) begin
      @(negedge CLK);
      if (bus.out_valid && bus.out_ready) n++;
      @(posedge CLK); #1;
      cyc++;
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", bus.out_valid); end
    #2 RST = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL mid_out_last got %b exp 0", bus.out_last); end
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL mid_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.sram_en !== 1'b0)   begin errors++; $display("FAIL mid_sram_en got %b exp 0", bus.sram_en); end
    @(posedge CLK);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_in_ready got %b exp 1", bus.in_ready); end
    @(posedge CLK); #1;
    fill(200, 1'b0, cyc);
    drain(64);
    checks++; if (got_n != 64) begin errors++; $display("FAIL mid_count got %0d exp 64", got_n); end
    for (int k = 0; k < 64; k++) begin
      checks++; if (got_d[k] !== W'(200 + k)) begin errors++; $display("FAIL mid_data[%0d] got %0d exp %0d", k, got_d[k], 200 + k); end
    end
  endtask

  task automatic test_gaps_toggle();
    int cyc, n;
    n = 0;
    cyc = 0;
    while (n < 64 && cyc < 300) begin
      bus.in_valid  = (cyc % 3 != 2);
      bus.in_data   = W'(300 + n);
      bus.transpose = (n == 0) ? 1'b1 : 1'(cyc);
      @(negedge CLK);
      if (bus.in_valid) begin
        checks++;
        if (!(bus.sram_en === 1'b1 && bus.sram_we === 1'b1 && bus.sram_a === 6'(n) && bus.sram_di === W'(300 + n))) begin
          errors++;
          $display("FAIL gap_write[%0d] got en=%b we=%b a=%0d exp en=1 we=1 a=%0d", n, bus.sram_en, bus.sram_we, bus.sram_a, n);
        end
        n++;
      end else begin
        checks++; if (bus.sram_en !== 1'b0) begin errors++; $display("FAIL gap_idle_en got %b exp 0", bus.sram_en); end
      end
      @(posedge CLK); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (n != 64) begin errors++; $display("FAIL gap_fill_count got %0d exp 64", n); end
    drain(64);
    checks++; if (got_n != 64) begin errors++; $display("FAIL gap_count got %0d exp 64", got_n); end
    for (int k = 0; k < 64; k++) begin
      checks++; if (got_d[k] !== W'(300 + col_idx(k))) begin errors++; $display("FAIL gap_data[%0d] got %0d exp %0d", k, got_d[k], 300 + col_idx(k)); end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.transpose = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_row_major();
    test_col_major();
    test_stall();
    test_back_to_back();
    test_reset_mid_drain();
    test_gaps_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
